// File: rtl/slc3_datapath_param.sv
// -----------------------------------------------------------------------------
// slc3_datapath_param
//
// Parametrised SLC-3 datapath. It holds PC, MAR, MDR, IR, an 8-entry register
// file, the ALU, the address adder, the NZP condition codes and BEN. The
// internal bus is a one-hot gate multiplexer. A small request/ready FSM lets
// the control unit wait on memory with variable latency.
//
// Parameters
//   WIDTH    datapath width (>= 16). IR fields come from ir[15:0].
//   ADDR_W   external address width. MAR is zero-extended or truncated to fit.
//   RESET_PC value loaded into PC on reset.
//
// Ports
//   Clk, Reset               clock, synchronous active-high reset
//   gate_pc/mdr/alu/marmux   bus drive selects (priority in that order)
//   ld_pc/mar/mdr/ir/reg/cc/ben  register load enables
//   pcmux, addr2mux, aluk    2-bit selects
//   drmux, sr1mux, sr2mux, addr1mux  1-bit selects
//   mem_rd, mem_wr           single-cycle pulses that start an access
//   mem_ready, mem_rdata     memory completion and read data
//   mem_req, mem_we          request strobe and write qualifier
//   mem_addr, mem_wdata      access address (latched at start) and write data
//   mem_busy, mem_done       FSM not idle; one-cycle completion pulse
//   bus, pc, mar, mdr, ir    internal state for debug displays
//   nzp, ben                 condition codes and branch enable
//
// Optional feature
//   SLC3_DP_BUS_CHECK_EN     adds output bus_conflict, a sticky flag set when
//                            two or more bus gates were asserted in one cycle.
// -----------------------------------------------------------------------------
module slc3_datapath_param #(
  parameter int               WIDTH    = 16,
  parameter int               ADDR_W   = 20,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              gate_pc,
  input  logic              gate_mdr,
  input  logic              gate_alu,
  input  logic              gate_marmux,
  input  logic              ld_pc,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              ld_ir,
  input  logic              ld_reg,
  input  logic              ld_cc,
  input  logic              ld_ben,
  input  logic [1:0]        pcmux,
  input  logic [1:0]        addr2mux,
  input  logic [1:0]        aluk,
  input  logic              drmux,
  input  logic              sr1mux,
  input  logic              sr2mux,
  input  logic              addr1mux,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              mem_ready,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [WIDTH-1:0]  bus,
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  mar,
  output logic [WIDTH-1:0]  mdr,
  output logic [WIDTH-1:0]  ir,
  output logic [2:0]        nzp,
  output logic              ben
`ifdef SLC3_DP_BUS_CHECK_EN
  ,
  output logic              bus_conflict
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2
  } mem_state_e;

  mem_state_e state_q, state_d;

  logic [WIDTH-1:0] regs [8];

  logic [2:0]       sr1, sr2, dr;
  logic [WIDTH-1:0] sr1_val, sr2_val;
  logic [WIDTH-1:0] sext5, sext6, sext9, sext11;
  logic [WIDTH-1:0] alu_b, alu_out;
  logic [WIDTH-1:0] addr1_val, addr2_val, adder_out;
  logic [WIDTH-1:0] pc_next;
  logic [2:0]       cc_from_bus;
  logic             mem_start;

  logic [ADDR_W+WIDTH-1:0] addr_wide;
  logic [ADDR_W-1:0]       addr_q;

  // ---------------------------------------------------------------------------
  // Operand selection and sign extension
  // ---------------------------------------------------------------------------
  assign sr1 = sr1mux ? ir[8:6] : ir[11:9];
  assign sr2 = ir[2:0];
  assign dr  = drmux ? 3'd7 : ir[11:9];

  assign sr1_val = regs[sr1];
  assign sr2_val = regs[sr2];

  assign sext5  = {{(WIDTH-5){ir[4]}},   ir[4:0]};
  assign sext6  = {{(WIDTH-6){ir[5]}},   ir[5:0]};
  assign sext9  = {{(WIDTH-9){ir[8]}},   ir[8:0]};
  assign sext11 = {{(WIDTH-11){ir[10]}}, ir[10:0]};

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  assign alu_b = sr2mux ? sext5 : sr2_val;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    alu_out = '0;
    case (aluk)
      2'b00:   alu_out = sr1_val + alu_b;
      2'b01:   alu_out = sr1_val & alu_b;
      2'b10:   alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address adder and PC source
  // ---------------------------------------------------------------------------
  assign addr1_val = addr1mux ? sr1_val : pc;

  always_comb begin
    addr2_val = '0;
    case (addr2mux)
      2'b00:   addr2_val = '0;
      2'b01:   addr2_val = sext6;
      2'b10:   addr2_val = sext9;
      default: addr2_val = sext11;
    endcase
  end

  assign adder_out = addr1_val + addr2_val;

  always_comb begin
    pc_next = pc;
    case (pcmux)
      2'b00:   pc_next = pc + WIDTH'(1);
      2'b01:   pc_next = bus;
      2'b10:   pc_next = adder_out;
      default: pc_next = pc;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus: fixed-priority gate multiplexer, zero when nothing drives it
  // ---------------------------------------------------------------------------
  always_comb begin
    bus = '0;
    if (gate_pc)          bus = pc;
    else if (gate_mdr)    bus = mdr;
    else if (gate_alu)    bus = alu_out;
    else if (gate_marmux) bus = adder_out;
  end

  assign cc_from_bus = bus[WIDTH-1] ? 3'b100 :
                       (bus == '0)  ? 3'b010 : 3'b001;

  // ---------------------------------------------------------------------------
  // Architectural registers
  // ---------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values; BEN therefore sees the old IR and NZP even
  // when ld_ir or ld_cc fires in the same cycle.
  // NOTE: the register file is small and must read as zero after reset, so it
  // is reset element by element rather than left uninitialised like a RAM.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc  <= RESET_PC;
      mar <= '0;
      ir  <= '0;
      nzp <= 3'b010;
      ben <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (ld_pc)  pc       <= pc_next;
      if (ld_mar) mar      <= bus;
      if (ld_ir)  ir       <= bus;
      if (ld_reg) regs[dr] <= bus;
      if (ld_cc)  nzp      <= cc_from_bus;
      if (ld_ben) ben      <= (ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0]);
    end
  end

  // MDR is owned by the CPU only while idle; during a read it takes memory data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mdr <= '0;
    end else if (state_q == S_IDLE) begin
      if (ld_mdr) mdr <= bus;
    end else if (state_q == S_RD_WAIT && mem_ready) begin
      mdr <= mem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_rd)      state_d = S_RD_WAIT;
        else if (mem_wr) state_d = S_WR_WAIT;
      end
      S_RD_WAIT, S_WR_WAIT: begin
        if (mem_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_busy = 1'b0;
    case (state_q)
      S_RD_WAIT: begin
        mem_req  = 1'b1;
        mem_busy = 1'b1;
      end
      S_WR_WAIT: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_busy = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) mem_done <= 1'b0;
    else       mem_done <= (state_q != S_IDLE) && mem_ready;
  end

  // The address is captured when an access starts, so a later ld_mar does not
  // disturb the transfer in flight. Zero-extending into a wide temporary then
  // taking the low ADDR_W bits covers both the widening and narrowing cases.
  assign mem_start = (state_q == S_IDLE) && (mem_rd || mem_wr);
  assign addr_wide = {{ADDR_W{1'b0}}, mar};

  always_ff @(posedge Clk) begin
    if (Reset)          addr_q <= '0;
    else if (mem_start) addr_q <= addr_wide[ADDR_W-1:0];
  end

  assign mem_addr = addr_q;

  // MDR cannot change while a write is pending, so it is the write data as-is.
  assign mem_wdata = mdr;

  // Opcode bits and the spare upper part of the address temporary are not
  // used by the datapath.
  logic unused_bits;
  assign unused_bits = ^{ir[WIDTH-1:12], addr_wide[ADDR_W+WIDTH-1:ADDR_W]};

`ifdef SLC3_DP_BUS_CHECK_EN
  logic [2:0] gate_count;
  assign gate_count = 3'(gate_pc) + 3'(gate_mdr) + 3'(gate_alu) + 3'(gate_marmux);

  always_ff @(posedge Clk) begin
    if (Reset)                  bus_conflict <= 1'b0;
    else if (gate_count >= 3'd2) bus_conflict <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_slc3_datapath_param.sv
// -----------------------------------------------------------------------------
// tb_slc3_datapath_param
//
// Directed scenarios followed by randomized cycles, every cycle compared with
// a behavioural model of the datapath kept in this bench.
// -----------------------------------------------------------------------------
module tb_slc3_datapath_param;

  localparam int W = 16;
  localparam int A = 20;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic         ld_pc, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc, ld_ben;
  logic [1:0]   pcmux, addr2mux, aluk;
  logic         drmux, sr1mux, sr2mux, addr1mux;
  logic         mem_rd, mem_wr, mem_ready;
  logic [W-1:0] mem_rdata;
  logic         mem_req, mem_we, mem_busy, mem_done;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata, bus, pc, mar, mdr, ir;
  logic [2:0]   nzp;
  logic         ben;
`ifdef SLC3_DP_BUS_CHECK_EN
  logic         bus_conflict;
`endif

  slc3_datapath_param #(
    .WIDTH    (W),
    .ADDR_W   (A),
    .RESET_PC (16'h3000)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .gate_pc     (gate_pc),
    .gate_mdr    (gate_mdr),
    .gate_alu    (gate_alu),
    .gate_marmux (gate_marmux),
    .ld_pc       (ld_pc),
    .ld_mar      (ld_mar),
    .ld_mdr      (ld_mdr),
    .ld_ir       (ld_ir),
    .ld_reg      (ld_reg),
    .ld_cc       (ld_cc),
    .ld_ben      (ld_ben),
    .pcmux       (pcmux),
    .addr2mux    (addr2mux),
    .aluk        (aluk),
    .drmux       (drmux),
    .sr1mux      (sr1mux),
    .sr2mux      (sr2mux),
    .addr1mux    (addr1mux),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_busy    (mem_busy),
    .mem_done    (mem_done),
    .bus         (bus),
    .pc          (pc),
    .mar         (mar),
    .mdr         (mdr),
    .ir          (ir),
    .nzp         (nzp),
    .ben         (ben)
`ifdef SLC3_DP_BUS_CHECK_EN
    ,
    .bus_conflict(bus_conflict)
`endif
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  int req_cycles = 0;
  int done_pulses = 0;

  // Reference model state
  logic [W-1:0] m_pc, m_mar, m_mdr, m_ir;
  logic [W-1:0] m_r [8];
  logic [2:0]   m_nzp;
  logic         m_ben, m_busy, m_is_wr, m_done, m_conf;
  logic [W-1:0] m_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sx(input logic [W-1:0] v, input int bits);
    int val;
    val = int'(v) & ((1 << bits) - 1);
    if (val >= (1 << (bits - 1))) val -= (1 << bits);
    return W'(val);
  endfunction

  function automatic logic [W-1:0] m_sr1();
    return sr1mux ? m_r[m_ir[8:6]] : m_r[m_ir[11:9]];
  endfunction

  function automatic logic [W-1:0] m_alu();
    logic [W-1:0] a, b;
    a = m_sr1();
    b = sr2mux ? sx(m_ir, 5) : m_r[m_ir[2:0]];
    case (aluk)
      2'd0:    return W'((int'(a) + int'(b)) % 65536);
      2'd1:    return a & b;
      2'd2:    return W'(65535 - int'(a));
      default: return a;
    endcase
  endfunction

  function automatic logic [W-1:0] m_adder();
    int base, off;
    base = addr1mux ? int'(m_sr1()) : int'(m_pc);
    case (addr2mux)
      2'd0:    off = 0;
      2'd1:    off = int'(sx(m_ir, 6));
      2'd2:    off = int'(sx(m_ir, 9));
      default: off = int'(sx(m_ir, 11));
    endcase
    return W'((base + off) % 65536);
  endfunction

  function automatic logic [W-1:0] m_bus();
    if (gate_pc)     return m_pc;
    if (gate_mdr)    return m_mdr;
    if (gate_alu)    return m_alu();
    if (gate_marmux) return m_adder();
    return '0;
  endfunction

  task automatic model_reset();
    m_pc = 16'h3000; m_mar = '0; m_mdr = '0; m_ir = '0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_nzp = 3'b010; m_ben = 1'b0; m_busy = 1'b0; m_is_wr = 1'b0;
    m_done = 1'b0; m_conf = 1'b0; m_addr = '0;
  endtask

  task automatic idle();
    Reset = 0; gate_pc = 0; gate_mdr = 0; gate_alu = 0; gate_marmux = 0;
    ld_pc = 0; ld_mar = 0; ld_mdr = 0; ld_ir = 0; ld_reg = 0; ld_cc = 0; ld_ben = 0;
    pcmux = 0; addr2mux = 0; aluk = 0; drmux = 0; sr1mux = 0; sr2mux = 0; addr1mux = 0;
    mem_rd = 0; mem_wr = 0; mem_ready = 0; mem_rdata = '0;
  endtask

  // One clock: check combinational outputs before the edge, advance the model,
  // then check registered outputs just after the edge.
  task automatic tick();
    logic [W-1:0] b, n_pc, n_mar, n_ir, n_mdr, n_addr;
    logic [2:0]   n_nzp, dr;
    logic         n_ben, n_busy, n_wr, n_done;
    int           gates;
    @(negedge Clk);
    b = m_bus();
    check("bus", bus, b);
    check("mem_req", mem_req, m_busy);
    check("mem_we", mem_we, m_busy & m_is_wr);
    check("mem_busy_pre", mem_busy, m_busy);
    check("mem_wdata", mem_wdata, m_mdr);
    if (m_busy) check("mem_addr", mem_addr, {4'h0, m_addr});
    if (mem_req === 1'b1) req_cycles++;

    if (Reset) begin
      model_reset();
    end else begin
      dr     = drmux ? 3'd7 : m_ir[11:9];
      n_ben  = ld_ben ? ((m_ir[11] & m_nzp[2]) | (m_ir[10] & m_nzp[1]) | (m_ir[9] & m_nzp[0])) : m_ben;
      n_nzp  = ld_cc ? (b[W-1] ? 3'b100 : (b == 0) ? 3'b010 : 3'b001) : m_nzp;
      n_pc   = m_pc;
      if (ld_pc) begin
        case (pcmux)
          2'd0:    n_pc = W'((int'(m_pc) + 1) % 65536);
          2'd1:    n_pc = b;
          2'd2:    n_pc = m_adder();
          default: n_pc = m_pc;
        endcase
      end
      n_mar  = ld_mar ? b : m_mar;
      n_ir   = ld_ir ? b : m_ir;
      n_mdr  = m_mdr;
      if (!m_busy && ld_mdr) n_mdr = b;
      if (m_busy && !m_is_wr && mem_ready) n_mdr = mem_rdata;
      n_done = m_busy && mem_ready;
      n_busy = m_busy; n_wr = m_is_wr; n_addr = m_addr;
      if (!m_busy) begin
        if (mem_rd)      begin n_busy = 1; n_wr = 0; n_addr = m_mar; end
        else if (mem_wr) begin n_busy = 1; n_wr = 1; n_addr = m_mar; end
      end else if (mem_ready) begin
        n_busy = 0;
      end
      gates = int'(gate_pc) + int'(gate_mdr) + int'(gate_alu) + int'(gate_marmux);
      if (gates >= 2) m_conf = 1'b1;
      if (ld_reg) m_r[dr] = b;
      m_pc = n_pc; m_mar = n_mar; m_ir = n_ir; m_mdr = n_mdr; m_nzp = n_nzp;
      m_ben = n_ben; m_busy = n_busy; m_is_wr = n_wr; m_addr = n_addr; m_done = n_done;
    end

    @(posedge Clk);
    #1;
    check("pc", pc, m_pc);
    check("mar", mar, m_mar);
    check("mdr", mdr, m_mdr);
    check("ir", ir, m_ir);
    check("nzp", nzp, m_nzp);
    check("ben", ben, m_ben);
    check("mem_done", mem_done, m_done);
    check("mem_busy", mem_busy, m_busy);
`ifdef SLC3_DP_BUS_CHECK_EN
    check("bus_conflict", bus_conflict, m_conf);
`endif
    if (mem_done === 1'b1) done_pulses++;
  endtask

  task automatic mem_read(input logic [W-1:0] v);
    idle(); mem_rd = 1; tick();
    idle(); mem_ready = 1; mem_rdata = v; tick();
    idle();
  endtask

  task automatic set_ir(input logic [W-1:0] v);
    mem_read(v);
    gate_mdr = 1; ld_ir = 1; tick();
    idle();
  endtask

  task automatic set_reg(input int idx, input logic [W-1:0] v);
    set_ir(W'(idx << 9));
    mem_read(v);
    gate_mdr = 1; ld_reg = 1; tick();
    idle();
  endtask

  initial begin
    idle();
    Reset = 1;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    check("rst_pc", pc, 16'h3000);
    check("rst_nzp", nzp, 3'b010);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_bus", bus, 16'h0000);
    Reset = 0;

    // PC to MAR, then increment; wrap of PC+1
    gate_pc = 1; ld_mar = 1; tick(); idle();
    check("mar_from_pc", mar, 16'h3000);
    ld_pc = 1; pcmux = 2'b00; tick(); idle();
    check("pc_inc", pc, 16'h3001);
    gate_alu = 1; aluk = 2'b10; pcmux = 2'b01; ld_pc = 1; tick(); idle();
    check("pc_ffff", pc, 16'hFFFF);
    ld_pc = 1; pcmux = 2'b00; tick(); idle();
    check("pc_wrap", pc, 16'h0000);

    // Read with three wait cycles; a write pulse during the wait is ignored
    ld_pc = 1; repeat (16) tick(); idle();
    gate_pc = 1; ld_mar = 1; tick(); idle();
    check("mar_0010", mar, 16'h0010);
    req_cycles = 0; done_pulses = 0;
    mem_rd = 1; tick(); idle();
    for (int i = 0; i < 3; i++) begin
      mem_wr = (i == 1);
      tick();
      check("rd_wait_addr", mem_addr, 20'h00010);
    end
    idle(); mem_ready = 1; mem_rdata = 16'h1234; tick(); idle();
    check("rd_mdr", mdr, 16'h1234);
    check("rd_done", mem_done, 1'b1);
    tick();
    check("rd_done_clear", mem_done, 1'b0);
    check("rd_idle", mem_busy, 1'b0);
    check("rd_req_cycles", req_cycles, 4);
    check("rd_done_pulses", done_pulses, 1);

    // ADD R1,R2,R3 with R2=7, R3=FFFE
    set_reg(2, 16'h0007);
    set_reg(3, 16'hFFFE);
    set_ir(16'h1283);
    gate_alu = 1; aluk = 2'b00; sr1mux = 1; sr2mux = 0; drmux = 0; ld_reg = 1; ld_cc = 1;
    tick(); idle();
    check("add_nzp", nzp, 3'b001);
    gate_alu = 1; aluk = 2'b11; sr1mux = 0;
    #1;
    check("add_r1", bus, 16'h0005);
    idle();
    set_ir(16'h0C00); ld_ben = 1; tick(); idle();
    check("ben_nz", ben, 1'b0);
    set_ir(16'h0A00); ld_ben = 1; tick(); idle();
    check("ben_np", ben, 1'b1);

    // Write aborted by reset while waiting
    mem_read(16'hABCD);
    mem_wr = 1; tick(); idle();
    check("wr_we", mem_we, 1'b1);
    check("wr_wdata", mem_wdata, 16'hABCD);
    Reset = 1; tick(); idle();
    check("abort_req", mem_req, 1'b0);
    check("abort_mdr", mdr, 16'h0000);
    check("abort_busy", mem_busy, 1'b0);

`ifdef SLC3_DP_BUS_CHECK_EN
    gate_pc = 1; gate_alu = 1;
    #1;
    check("conflict_bus", bus, pc);
    tick(); idle();
    check("conflict_set", bus_conflict, 1'b1);
    repeat (3) tick();
    check("conflict_sticky", bus_conflict, 1'b1);
    Reset = 1; tick(); idle();
    check("conflict_clear", bus_conflict, 1'b0);
`endif

    // Randomized cycles against the model
    for (int n = 0; n < 600; n++) begin
      Reset       = ($urandom_range(0, 63) == 0);
      gate_pc     = ($urandom_range(0, 3) == 0);
      gate_mdr    = ($urandom_range(0, 3) == 0);
      gate_alu    = ($urandom_range(0, 2) == 0);
      gate_marmux = ($urandom_range(0, 3) == 0);
      ld_pc       = ($urandom_range(0, 2) == 0);
      ld_mar      = ($urandom_range(0, 2) == 0);
      ld_mdr      = ($urandom_range(0, 2) == 0);
      ld_ir       = ($urandom_range(0, 2) == 0);
      ld_reg      = ($urandom_range(0, 1) == 0);
      ld_cc       = ($urandom_range(0, 1) == 0);
      ld_ben      = ($urandom_range(0, 1) == 0);
      pcmux       = 2'($urandom_range(0, 3));
      addr2mux    = 2'($urandom_range(0, 3));
      aluk        = 2'($urandom_range(0, 3));
      drmux       = 1'($urandom_range(0, 1));
      sr1mux      = 1'($urandom_range(0, 1));
      sr2mux      = 1'($urandom_range(0, 1));
      addr1mux    = 1'($urandom_range(0, 1));
      mem_rd      = ($urandom_range(0, 5) == 0);
      mem_wr      = ($urandom_range(0, 5) == 0);
      mem_ready   = ($urandom_range(0, 2) == 0);
      mem_rdata   = W'($urandom);
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
